// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared FSM state type and default width for bit_serial_adder
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} serial_adder_state_t;
  localparam int SERIAL_ADDER_DEFAULT_WIDTH = 8;
endpackage

// File: rtl/full_adder_using_half_adder.sv
// full_adder_using_half_adder: one-bit full adder built from two half-adder stages
module full_adder_using_half_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);
  logic s1, c1;
  assign s1    = a ^ b;
  assign c1    = a & b;
  assign sum   = s1 ^ c_in;
  assign c_out = c1 | (s1 & c_in);
endmodule

// File: rtl/bit_serial_adder.sv
// bit_serial_adder: LSB-first serial adder, one bit per clock; SERIAL_ADDER_SUB_EN adds in_sub (a - b)
module bit_serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = SERIAL_ADDER_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             in_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c_out,
  output logic             out_ovf
);
  localparam int CW = $clog2(WIDTH);
  serial_adder_state_t state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d, b_sr_q, b_sr_d, sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d, c_msb_q, c_msb_d;
  logic             fa_s, fa_c, sub, last;
`ifdef SERIAL_ADDER_SUB_EN
  assign sub = in_sub;
`else
  assign sub = 1'b0;
`endif
  full_adder_using_half_adder u_fa (
    .a    (a_sr_q[0]),
    .b    (b_sr_q[0]),
    .c_in (carry_q),
    .sum  (fa_s),
    .c_out(fa_c)
  );
  assign last      = cnt_q == CW'(WIDTH - 1);
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign out_sum   = sum_sr_q;
  assign out_c_out = carry_q;
  assign out_ovf   = c_msb_q ^ carry_q;
  // next-state: load on accept, shift one bit per RUN cycle, hold in DONE until drained
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    c_msb_d  = c_msb_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_sr_d  = in_a;
        b_sr_d  = sub ? ~in_b : in_b;
        carry_d = sub | in_c_in;
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        sum_sr_d = {fa_s, sum_sr_q[WIDTH-1:1]};
        carry_d  = fa_c;
        cnt_d    = last ? cnt_q : cnt_q + 1'b1;
        c_msb_d  = last ? carry_q : c_msb_q;
        state_d  = last ? DONE : RUN;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset overrides every transition
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      c_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      c_msb_q  <= c_msb_d;
    end
  end
endmodule
